conv2x2_stream: RTL and testbench

//  Streaming 2x2 convolution engine: accepts an IMG_H x IMG_W pixel frame in raster order,

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv2x2_line_buf.sv | 41 ++++
 rtl/conv2x2_stream.sv | 182 ++++++++++++++++++
 tb/tb_conv2x2_stream.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg -- shared types and helpers for the conv2x2_stream engine.
//   state_e        : frame-control FSM states
//   KERN_INIT_DEF  : default reset kernel, packed {K3,K2,K1,K0}
//   conv_out_w()   : signed window-result width for given pixel/coef widths
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] KERN_INIT_DEF = 16'h2222;

  // Each product of an unsigned pixel and signed coefficient fits in
  // PIX_W+COEF_W signed bits; summing four adds two more.
  function automatic int conv_out_w(input int pix_w, input int coef_w);
    return pix_w + coef_w + 2;
  endfunction

endpackage

// File: rtl/conv2x2_line_buf.sv
// conv2x2_line_buf -- DEPTH-entry pixel shift buffer for the 2x2 window.
// Shifts one entry per enabled cycle. With DEPTH equal to the frame width,
// before the pixel at (r,c) is shifted in:
//   prev_o    : pixel (r, c-1)     -- bottom-left of the window
//   tap_c_o   : pixel (r-1, c)     -- top-right of the window
//   tap_cm1_o : pixel (r-1, c-1)   -- top-left of the window
// Ports: clk_i, rst_ni (async active-low), en_i, din_i[W], prev_o, tap_c_o, tap_cm1_o.
module conv2x2_line_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] prev_o,
  output logic [W-1:0] tap_c_o,
  output logic [W-1:0] tap_cm1_o
);

  logic [W-1:0] sr_q [DEPTH];
  // One stage beyond the line: holds the entry that just fell off the end,
  // which is the top-left pixel of the next window.
  logic [W-1:0] tail_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      tail_q <= '0;
    end else if (en_i) begin
      sr_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      tail_q <= sr_q[DEPTH-1];
    end
  end

  assign prev_o    = sr_q[0];
  assign tap_c_o   = sr_q[DEPTH-1];
  assign tap_cm1_o = tail_q;

endmodule

// File: rtl/conv2x2_stream.sv
// conv2x2_stream -- streaming 2x2 (stride 1) convolution over an IMG_H x IMG_W
// raster frame with a runtime-loadable signed kernel and a running frame sum.
// Optional feature: define CONV_RELU_EN to clamp negative window results to 0
// before conv_out and before accumulation.
// Ports:
//   CLK, RSTn (async active-low)
//   start, kern_we/kern_idx/kern_data : control, honoured in IDLE only
//   pix_valid/pix_data/pix_ready      : pixel input handshake (ready in RUN)
//   conv_valid/conv_out/conv_row/conv_col : per-window result strobe (latency 1)
//   sum_out : running signed sum of conv_out, wraps at ACC_W
//   busy    : FSM not IDLE;  done : one-cycle frame-end strobe
module conv2x2_stream
  import conv_pkg::*;
#(
  parameter int PIX_W  = 4,
  parameter int COEF_W = 4,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int ACC_W  = 16,
  parameter logic [4*COEF_W-1:0] KERN_INIT = KERN_INIT_DEF,
  localparam int OUT_W = conv_out_w(PIX_W, COEF_W),
  localparam int ROW_W = $clog2(IMG_H),
  localparam int COL_W = $clog2(IMG_W)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              kern_we,
  input  logic [1:0]        kern_idx,
  input  logic [COEF_W-1:0] kern_data,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              conv_valid,
  output logic [OUT_W-1:0]  conv_out,
  output logic [ROW_W-1:0]  conv_row,
  output logic [COL_W-1:0]  conv_col,
  output logic [ACC_W-1:0]  sum_out,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic signed [COEF_W-1:0] kern_q [4];
  logic signed [COEF_W-1:0] kern_d [4];
  logic                     conv_valid_q, conv_valid_d;
  logic signed [OUT_W-1:0]  conv_out_q, conv_out_d;
  logic [ROW_W-1:0]         conv_row_q, conv_row_d;
  logic [COL_W-1:0]         conv_col_q, conv_col_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;

  logic                     accept, last_pix, win_ok, col_last, row_last;
  logic [PIX_W-1:0]         px_tl, px_tr, px_bl;
  logic signed [OUT_W-1:0]  conv_raw, conv_res;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == RUN);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // ---------------------------------------------------------------- window
  assign accept   = pix_valid & pix_ready;
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign last_pix = row_last & col_last;
  assign win_ok   = (row_q != '0) && (col_q != '0);

  conv2x2_line_buf #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_line_buf (
    .clk_i     (CLK),
    .rst_ni    (RSTn),
    .en_i      (accept),
    .din_i     (pix_data),
    .prev_o    (px_bl),
    .tap_c_o   (px_tr),
    .tap_cm1_o (px_tl)
  );

  // Pixels are zero-extended to signed before multiplying; all operands are
  // widened to OUT_W, which holds the full-precision result.
  always_comb begin
    conv_raw = OUT_W'($signed({1'b0, px_tl}))    * OUT_W'(kern_q[0])
             + OUT_W'($signed({1'b0, px_tr}))    * OUT_W'(kern_q[1])
             + OUT_W'($signed({1'b0, px_bl}))    * OUT_W'(kern_q[2])
             + OUT_W'($signed({1'b0, pix_data})) * OUT_W'(kern_q[3]);
  end

`ifdef CONV_RELU_EN
  assign conv_res = conv_raw[OUT_W-1] ? '0 : conv_raw;
`else
  assign conv_res = conv_raw;
`endif

  // ---------------------------------------------------------------- datapath
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    kern_d       = kern_q;
    conv_valid_d = 1'b0;
    conv_out_d   = conv_out_q;
    conv_row_d   = conv_row_q;
    conv_col_d   = conv_col_q;
    sum_d        = sum_q;

    if (state_q == IDLE) begin
      if (kern_we) kern_d[kern_idx] = kern_data;
      if (start) begin
        sum_d = '0;
        row_d = '0;
        col_d = '0;
      end
    end

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (win_ok) begin
        conv_valid_d = 1'b1;
        conv_out_d   = conv_res;
        conv_row_d   = row_q - 1'b1;
        conv_col_d   = col_q - 1'b1;
        sum_d        = sum_q + ACC_W'(conv_res);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_q        <= '0;
      col_q        <= '0;
      for (int unsigned i = 0; i < 4; i++) kern_q[i] <= KERN_INIT[i*COEF_W +: COEF_W];
      conv_valid_q <= 1'b0;
      conv_out_q   <= '0;
      conv_row_q   <= '0;
      conv_col_q   <= '0;
      sum_q        <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      kern_q       <= kern_d;
      conv_valid_q <= conv_valid_d;
      conv_out_q   <= conv_out_d;
      conv_row_q   <= conv_row_d;
      conv_col_q   <= conv_col_d;
      sum_q        <= sum_d;
    end
  end

  assign conv_valid = conv_valid_q;
  assign conv_out   = conv_out_q;
  assign conv_row   = conv_row_q;
  assign conv_col   = conv_col_q;
  assign sum_out    = sum_q;

endmodule

// File: tb/tb_conv2x2_stream.sv
// Directed bench for conv2x2_stream: a default instance plus a 12-bit
// accumulator instance sharing the same stimulus.
module tb_conv2x2_stream;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       start = 1'b0;
  logic       kern_we = 1'b0;
  logic [1:0] kern_idx = '0;
  logic [3:0] kern_data = '0;
  logic       pix_valid = 1'b0;
  logic [3:0] pix_data = '0;

  logic        pix_ready, conv_valid, busy, done;
  logic [9:0]  conv_out;
  logic [1:0]  conv_row, conv_col;
  logic [15:0] sum_out;

  logic        pix_ready_b, conv_valid_b, busy_b, done_b;
  logic [9:0]  conv_out_b;
  logic [1:0]  conv_row_b, conv_col_b;
  logic [11:0] sum_out_b;

  conv2x2_stream dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .kern_we(kern_we), .kern_idx(kern_idx),
    .kern_data(kern_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .conv_valid(conv_valid), .conv_out(conv_out),
    .conv_row(conv_row), .conv_col(conv_col), .sum_out(sum_out), .busy(busy), .done(done)
  );

  conv2x2_stream #(.ACC_W(12)) dut_w (
    .CLK(CLK), .RSTn(RSTn), .start(start), .kern_we(kern_we), .kern_idx(kern_idx),
    .kern_data(kern_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready_b), .conv_valid(conv_valid_b), .conv_out(conv_out_b),
    .conv_row(conv_row_b), .conv_col(conv_col_b), .sum_out(sum_out_b), .busy(busy_b), .done(done_b)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [9:0] v;
    logic [1:0] r;
    logic [1:0] c;
  } res_t;

  res_t       q[$];
  int         done_cnt  = 0;
  int         bad_valid = 0;
  logic       acc_seen  = 1'b0;
  logic [3:0] frame [16];

  int exp1 [9] = '{2, 6, 4, 8, 20, 12, 6, 14, 8};
`ifdef CONV_RELU_EN
  int exp3 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int sum3     = 0;
`else
  int exp3 [9] = '{0, 0, 0, 0, -1, -2, 0, -3, -4};
  int sum3     = -10;
`endif

  // Capture results away from the active edge; acc_seen remembers whether the
  // previous edge accepted a pixel, so strobes without one are flagged.
  always @(negedge CLK) begin
    if (conv_valid) begin
      q.push_back('{conv_out, conv_row, conv_col});
      if (!acc_seen) bad_valid++;
    end
    if (done) done_cnt++;
    acc_seen = pix_valid & pix_ready;
  end

  task automatic set_test_frame();
    logic [3:0] vals [16] = '{0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0};
    for (int i = 0; i < 16; i++) frame[i] = vals[i];
  endtask

  task automatic apply_reset();
    RSTn = 1'b0; start = 1'b0; kern_we = 1'b0; pix_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  task automatic load_kernel(input logic [1:0] idx, input logic [3:0] val);
    kern_we = 1'b1; kern_idx = idx; kern_data = val;
    @(posedge CLK); #1;
    kern_we = 1'b0;
  endtask

  task automatic begin_frame();
    q.delete(); done_cnt = 0; bad_valid = 0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // gap: idle every other cycle; inject: pulse start+kern_we mid-frame.
  task automatic send_pixels(input int n, input bit gap, input bit inject);
    int i = 0;
    int cyc = 0;
    logic accepted;
    while (i < n && cyc < 100) begin
      if (gap && (cyc % 2 == 1)) pix_valid = 1'b0;
      else begin pix_valid = 1'b1; pix_data = frame[i]; end
      if (inject && cyc == 3) begin
        start = 1'b1; kern_we = 1'b1; kern_idx = 2'd0; kern_data = 4'hF;
      end else begin
        start = 1'b0; kern_we = 1'b0;
      end
      @(negedge CLK);
      accepted = pix_valid & pix_ready;
      @(posedge CLK); #1;
      if (accepted) i++;
      cyc++;
    end
    pix_valid = 1'b0; start = 1'b0; kern_we = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (done_cnt > 0) ok = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({busy, done, pix_ready, conv_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pix_ready, conv_valid});
    end
    n_tests++;
    if ({conv_out, conv_row, conv_col, sum_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: got out=%0d sum=%0d expected 0", conv_out, sum_out);
    end
    apply_reset();
  endtask

  task automatic test_stream();
    bit ok;
    res_t e;
    set_test_frame();
    begin_frame();
    send_pixels(16, 1'b0, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL t1_done_timeout: got no done expected done"); end
    n_tests++;
    if (q.size() !== 9) begin n_fail++; $display("FAIL t1_count: got %0d expected 9", q.size()); end
    for (int i = 0; i < 9; i++) begin
      res_t g = (i < q.size()) ? q[i] : 'x;
      e = '{10'(exp1[i]), 2'(i / 3), 2'(i % 3)};
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL t1_win%0d: got %h expected %h", i, g, e); end
    end
    n_tests++;
    if (sum_out !== 16'd80) begin n_fail++; $display("FAIL t1_sum: got %0d expected 80", sum_out); end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL t1_done_once: got %0d expected 1", done_cnt); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_gaps();
    bit ok;
    res_t e;
    set_test_frame();
    begin_frame();
    send_pixels(16, 1'b1, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() !== 9) begin
      n_fail++; $display("FAIL t2_count: got %0d done=%0d expected 9 done=1", q.size(), ok);
    end
    for (int i = 0; i < 9; i++) begin
      res_t g = (i < q.size()) ? q[i] : 'x;
      e = '{10'(exp1[i]), 2'(i / 3), 2'(i % 3)};
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL t2_win%0d: got %h expected %h", i, g, e); end
    end
    n_tests++;
    if (bad_valid !== 0) begin n_fail++; $display("FAIL t2_spurious_valid: got %0d expected 0", bad_valid); end
    n_tests++;
    if (sum_out !== 16'd80) begin n_fail++; $display("FAIL t2_sum: got %0d expected 80", sum_out); end
  endtask

  task automatic test_kernel_load();
    bit ok;
    res_t e;
    load_kernel(2'd0, 4'hF);
    load_kernel(2'd1, 4'h0);
    load_kernel(2'd2, 4'h0);
    load_kernel(2'd3, 4'h0);
    set_test_frame();
    begin_frame();
    send_pixels(16, 1'b0, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() !== 9) begin
      n_fail++; $display("FAIL t3_count: got %0d done=%0d expected 9 done=1", q.size(), ok);
    end
    for (int i = 0; i < 9; i++) begin
      res_t g = (i < q.size()) ? q[i] : 'x;
      e = '{10'(exp3[i]), 2'(i / 3), 2'(i % 3)};
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL t3_win%0d: got %h expected %h", i, g, e); end
    end
    n_tests++;
    if (sum_out !== 16'(sum3)) begin n_fail++; $display("FAIL t3_sum: got %0d expected %0d", $signed(sum_out), sum3); end
  endtask

  task automatic test_midframe_reset();
    bit ok;
    set_test_frame();
    begin_frame();
    send_pixels(6, 1'b0, 1'b0);
    RSTn = 1'b0;
    #2;
    n_tests++;
    if ({busy, pix_ready, conv_valid, sum_out, conv_out} !== '0) begin
      n_fail++; $display("FAIL t4_reset_outputs: got busy=%b sum=%0d out=%0d expected 0", busy, sum_out, conv_out);
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    begin_frame();
    send_pixels(16, 1'b0, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() !== 9) begin
      n_fail++; $display("FAIL t4_count: got %0d done=%0d expected 9 done=1", q.size(), ok);
    end
    n_tests++;
    if (sum_out !== 16'd80) begin n_fail++; $display("FAIL t4_sum: got %0d expected 80", $signed(sum_out)); end
  endtask

  task automatic test_ignored_ctrl();
    bit ok;
    res_t e;
    set_test_frame();
    begin_frame();
    send_pixels(16, 1'b0, 1'b1);
    wait_done(ok);
    n_tests++;
    if (!ok || q.size() !== 9) begin
      n_fail++; $display("FAIL t5_count: got %0d done=%0d expected 9 done=1", q.size(), ok);
    end
    for (int i = 0; i < 9; i++) begin
      res_t g = (i < q.size()) ? q[i] : 'x;
      e = '{10'(exp1[i]), 2'(i / 3), 2'(i % 3)};
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL t5_win%0d: got %h expected %h", i, g, e); end
    end
    n_tests++;
    if (sum_out !== 16'd80 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_sum_idle: got sum=%0d busy=%b expected 80 0", sum_out, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) load_kernel(2'(i), 4'd7);
    for (int i = 0; i < 16; i++) frame[i] = 4'd15;
    begin_frame();
    send_pixels(16, 1'b0, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL t6_done_timeout: got no done expected done"); end
    n_tests++;
    if (conv_out_b !== 10'd420) begin n_fail++; $display("FAIL t6_conv: got %0d expected 420", conv_out_b); end
    n_tests++;
    if (sum_out_b !== 12'hEC4) begin n_fail++; $display("FAIL t6_wrap_sum: got %0d expected -316", $signed(sum_out_b)); end
    n_tests++;
    if (sum_out !== 16'd3780) begin n_fail++; $display("FAIL t6_wide_sum: got %0d expected 3780", sum_out); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_kernel_load();
    test_midframe_reset();
    test_ignored_ctrl();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
